// File: rtl/alu_seq_if.sv
// Request/response bundle between the datapath and alu_seq: operands and op
// in, registered result, flags and the busy/done handshake out.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             co;
    logic             zf;
    logic             nf;
    logic             of;

    modport master (
        output start, op, A, B, ci,
        input  busy, done, result, result_hi, co, zf, nf, of
    );

    modport slave (
        input  start, op, A, B, ci,
        output busy, done, result, result_hi, co, zf, nf, of
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with registered result/flags: single-cycle arithmetic, logic
// and shift ops, plus an iterative WIDTH-cycle shift-add unsigned multiply.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SBB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             state_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CW-1:0]      cnt_r;

    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_hi_r;
    logic               co_r;
    logic               zf_r;
    logic               nf_r;
    logic               of_r;

    logic [WIDTH:0]     ext_a_s;
    logic [WIDTH:0]     ext_b_s;
    logic [WIDTH:0]     ext_ci_s;
    logic [WIDTH:0]     alu_s;
    logic               alu_of_s;
    logic [2*WIDTH-1:0] acc_next_s;

    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    assign ext_a_s    = {1'b0, bus.A};
    assign ext_b_s    = {1'b0, bus.B};
    assign ext_ci_s   = {{WIDTH{1'b0}}, bus.ci};
    assign acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

    // Single-cycle ops; alu_s is laid out as {co, result}. MUL/illegal give 0.
    always_comb begin
        alu_s = {(WIDTH+1){1'b0}};
        case (bus.op)
            OP_ADD:  alu_s = ext_a_s + ext_b_s;
            OP_ADC:  alu_s = ext_a_s + ext_b_s + ext_ci_s;
            OP_SBB:  alu_s = ext_a_s - ext_b_s - ext_ci_s;
            OP_AND:  alu_s = {1'b0, bus.A & bus.B};
            OP_OR:   alu_s = {1'b0, bus.A | bus.B};
            OP_XOR:  alu_s = {1'b0, bus.A ^ bus.B};
            OP_NOT:  alu_s = {1'b0, ~bus.A};
            OP_SHL:  alu_s = {bus.A, bus.ci};
            OP_SHR:  alu_s = {bus.A[0], bus.ci, bus.A[WIDTH-1:1]};
            default: alu_s = {(WIDTH+1){1'b0}};
        endcase
    end

    // Signed overflow is only meaningful for the add/subtract family.
    always_comb begin
        alu_of_s = 1'b0;
        if (bus.op == OP_ADD || bus.op == OP_ADC) begin
            alu_of_s = add_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], alu_s[WIDTH-1]);
        end else if (bus.op == OP_SBB) begin
            alu_of_s = sub_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], alu_s[WIDTH-1]);
        end else begin
            alu_of_s = 1'b0;
        end
    end

    // Control FSM, multiply datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            mcand_r     <= {(2*WIDTH){1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            co_r        <= 1'b0;
            zf_r        <= 1'b0;
            nf_r        <= 1'b0;
            of_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MUL) begin
                            mcand_r  <= {{WIDTH{1'b0}}, bus.A};
                            mplier_r <= bus.B;
                            acc_r    <= {(2*WIDTH){1'b0}};
                            cnt_r    <= {CW{1'b0}};
                            busy_r   <= 1'b1;
                            state_r  <= S_MUL;
                        end else begin
                            result_r    <= alu_s[WIDTH-1:0];
                            result_hi_r <= {WIDTH{1'b0}};
                            co_r        <= alu_s[WIDTH];
                            zf_r        <= (alu_s[WIDTH-1:0] == {WIDTH{1'b0}});
                            nf_r        <= alu_s[WIDTH-1];
                            of_r        <= alu_of_s;
                            done_r      <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_MUL: begin
                    // One multiplier bit per edge; the last pass publishes acc_next_s.
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == LAST_CNT) begin
                        result_r    <= acc_next_s[WIDTH-1:0];
                        result_hi_r <= acc_next_s[2*WIDTH-1:WIDTH];
                        co_r        <= |acc_next_s[2*WIDTH-1:WIDTH];
                        zf_r        <= (acc_next_s == {(2*WIDTH){1'b0}});
                        nf_r        <= acc_next_s[2*WIDTH-1];
                        of_r        <= 1'b0;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r <= S_MUL;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.result_hi = result_hi_r;
    assign bus.co        = co_r;
    assign bus.zf        = zf_r;
    assign bus.nf        = nf_r;
    assign bus.of        = of_r;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases plus random ops, checked
// against an integer-arithmetic reference model by a decoupled monitor.
module tb_alu_seq;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    typedef struct {
        int res; int hi; int co; int zf; int nf; int of; int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   ncyc  = 0;
    exp_t sb[$];

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= HALF) ? v - (1 << W) : v;
    endfunction

    function automatic exp_t model(input int op, input int a, input int b, input int c);
        exp_t e;
        int   s;
        int   ss;
        e = '{default: 0};
        case (op)
            0: begin s = a + b;     ss = sgn(a) + sgn(b);     e.res = s & MASK; e.co = s >> W;
                     e.of = (ss > HALF - 1 || ss < -HALF); end
            1: begin s = a + b + c; ss = sgn(a) + sgn(b) + c; e.res = s & MASK; e.co = s >> W;
                     e.of = (ss > HALF - 1 || ss < -HALF); end
            2: begin s = a - b - c; ss = sgn(a) - sgn(b) - c; e.res = s & MASK; e.co = (s < 0);
                     e.of = (ss > HALF - 1 || ss < -HALF); end
            3: e.res = a & b;
            4: e.res = a | b;
            5: e.res = a ^ b;
            6: e.res = ~a & MASK;
            7: begin e.res = ((a << 1) | c) & MASK; e.co = (a >> (W - 1)) & 1; end
            8: begin e.res = (a >> 1) | (c << (W - 1)); e.co = a & 1; end
            9: begin s = a * b; e.res = s & MASK; e.hi = s >> W; e.co = (e.hi != 0);
                     e.zf = (s == 0); e.nf = (e.hi >> (W - 1)) & 1; end
            default: e.res = 0;
        endcase
        if (op != 9) begin
            e.zf = (e.res == 0);
            e.nf = (e.res >> (W - 1)) & 1;
        end
        return e;
    endfunction

    // Drive one request at posedge+1; it is accepted on the following edge.
    task automatic issue(input int op, input int a, input int b, input int c);
        exp_t e;
        bus.op    = op[3:0];
        bus.A     = a[W-1:0];
        bus.B     = b[W-1:0];
        bus.ci    = c[0];
        bus.start = 1'b1;
        e     = model(op, a, b, c);
        e.due = ncyc + 2 + ((op == 9) ? W : 0);
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_result"}, int'(bus.result), 0);
        check({tag, "_result_hi"}, int'(bus.result_hi), 0);
        check({tag, "_flags"}, int'({bus.co, bus.zf, bus.nf, bus.of}), 0);
    endtask

    // Monitor: pop and compare whenever the DUT reports completion.
    initial forever begin
        exp_t e;
        @(negedge clk);
        ncyc++;
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", ncyc, e.due);
                check("result", int'(bus.result), e.res);
                check("result_hi", int'(bus.result_hi), e.hi);
                check("co", int'(bus.co), e.co);
                check("zf", int'(bus.zf), e.zf);
                check("nf", int'(bus.nf), e.nf);
                check("of", int'(bus.of), e.of);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t dropped;
        int   op;
        bus.start = 1'b0; bus.op = 4'd0; bus.A = '0; bus.B = '0; bus.ci = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        issue(0, 8'hFF, 8'h01, 0);
        issue(1, 8'h7F, 8'h00, 1);
        issue(2, 8'h00, 8'h00, 1);
        issue(2, 8'h80, 8'h01, 0);
        bus.start = 1'b0;
        wait_drain();

        // MUL with operand/start noise while busy, then SHR in the done cycle.
        issue(9, 8'hFF, 8'hFF, 0);
        check("mul_busy_start", int'(bus.busy), 1);
        bus.A = 8'h12; bus.B = 8'h34; bus.op = 4'd0; bus.start = 1'b1;
        repeat (W - 1) @(posedge clk);
        #1;
        check("mul_busy_last", int'(bus.busy), 1);
        @(posedge clk); #1;
        check("mul_busy_done", int'(bus.busy), 0);
        issue(8, 8'h01, 8'h00, 0);
        bus.start = 1'b0;
        wait_drain();

        // Reset after the 4th multiply iteration aborts with no done.
        issue(9, 8'hA5, 8'h3C, 0);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.start = 1'b1;
        dropped = sb.pop_back();
        @(posedge clk); #1;
        check_zero_outputs("mul_abort");
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        issue(0, 8'h03, 8'h04, 0);
        bus.start = 1'b0;
        wait_drain();

        // Streaming back-to-back requests, illegal op and logic ops.
        issue(0, 8'h10, 8'h22, 0);
        issue(5, 8'hF0, 8'h3C, 0);
        issue(7, 8'h81, 8'h00, 1);
        issue(12, 8'h55, 8'hAA, 1);
        for (int i = 3; i <= 6; i++) issue(i, $urandom_range(0, MASK), $urandom_range(0, MASK), 1);
        bus.start = 1'b0;
        wait_drain();

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 15);
            issue(op, $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 1));
            if (op == 9) begin
                bus.start = 1'b0;
                wait_drain();
            end
        end
        bus.start = 1'b0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
